// File: rtl/conv_enc_pkg.sv
// Shared types, default code parameters and parity helper for the rate-1/2
// convolutional encoder.
package conv_enc_pkg;

   typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;

   localparam int unsigned   DefaultK  = 3;
   localparam logic [2:0]    DefaultG0 = 3'b111;
   localparam logic [2:0]    DefaultG1 = 3'b101;
   localparam int unsigned   MaxK      = 9;

   function automatic logic parity(input logic [MaxK-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and generator parity; cx_next is the symbol for the
// current input bit u given the stored history.
module conv_enc_core
   import conv_enc_pkg::*;
#(
   parameter int unsigned    K  = DefaultK,
   parameter logic [K-1:0]   G0 = K'(DefaultG0),
   parameter logic [K-1:0]   G1 = K'(DefaultG1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       u,
   input  logic       shift_en,
   output logic [1:0] cx_next
);

   // sr[K-2] is the newest stored bit, sr[0] the oldest.
   logic [K-2:0] sr;
   logic [K-1:0] w;

   assign w       = {u, sr};
   assign cx_next = {parity(MaxK'(w & G0)), parity(MaxK'(w & G1))};

   always_ff @(posedge clk) begin
      if (!reset) begin
         sr <= '0;
      end else if (shift_en) begin
         sr <= {u, sr[K-2:1]};
      end
   end

endmodule

// File: rtl/conv_encoder_framer.sv
// Framed rate-1/2 convolutional encoder: valid/ready in, one code symbol per
// cycle out, K-1 zero tail bits appended to every frame.
module conv_encoder_framer
   import conv_enc_pkg::*;
#(
   parameter int unsigned    K  = DefaultK,
   parameter logic [K-1:0]   G0 = K'(DefaultG0),
   parameter logic [K-1:0]   G1 = K'(DefaultG1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_in,
   input  logic       d_valid,
   input  logic       d_last,
   output logic       d_ready,
   output logic [1:0] cx,
   output logic       cx_valid,
   output logic       cx_last,
   input  logic       cx_ready,
   output logic       busy
);

   localparam int unsigned TW = $clog2(K);

   enc_state_t    state;
   logic [TW-1:0] tail_cnt;
   logic          slot_free;
   logic          xfer;
   logic          emit;
   logic          last_tail;
   logic          u;
   logic [1:0]    cx_next;

   assign slot_free = !cx_valid || cx_ready;
   assign d_ready   = (state != TAIL) && slot_free && reset;
   assign xfer      = d_valid && d_ready;
   assign emit      = xfer || ((state == TAIL) && slot_free);
   assign last_tail = (state == TAIL) && (tail_cnt == '0);
   assign u         = (state == TAIL) ? 1'b0 : d_in;
   assign busy      = (state != IDLE);

   conv_enc_core #(
      .K  (K),
      .G0 (G0),
      .G1 (G1)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .u        (u),
      .shift_en (emit),
      .cx_next  (cx_next)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         tail_cnt <= '0;
         cx       <= '0;
         cx_valid <= 1'b0;
         cx_last  <= 1'b0;
      end else begin
         if (emit) begin
            cx       <= cx_next;
            cx_valid <= 1'b1;
            cx_last  <= last_tail;
         end else if (cx_ready) begin
            cx_valid <= 1'b0;
            cx_last  <= 1'b0;
         end

         case (state)
            IDLE, DATA: begin
               if (xfer) begin
                  if (d_last) begin
                     state    <= TAIL;
                     tail_cnt <= TW'(K - 2);
                  end else begin
                     state <= DATA;
                  end
               end
            end
            TAIL: begin
               if (slot_free) begin
                  if (tail_cnt == '0) begin
                     state <= IDLE;
                  end else begin
                     tail_cnt <= tail_cnt - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Scoreboard bench for conv_encoder_framer: a reference convolution model
// queues expected symbols per frame, a monitor pops them as cx is consumed.
module tb_conv_encoder_framer;

   localparam int unsigned  K  = 3;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;

   logic       clk      = 1'b0;
   logic       reset    = 1'b0;
   logic       d_in     = 1'b0;
   logic       d_valid  = 1'b0;
   logic       d_last   = 1'b0;
   logic       cx_ready = 1'b0;
   logic       d_ready;
   logic [1:0] cx;
   logic       cx_valid;
   logic       cx_last;
   logic       busy;

   conv_encoder_framer #(
      .K  (K),
      .G0 (G0),
      .G1 (G1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .d_in     (d_in),
      .d_valid  (d_valid),
      .d_last   (d_last),
      .d_ready  (d_ready),
      .cx       (cx),
      .cx_valid (cx_valid),
      .cx_last  (cx_last),
      .cx_ready (cx_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] cx;
      logic       last;
   } sym_t;

   sym_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_cons = 0;
   int   stall_base = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: scripted stalls

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Direct convolution over the input history; frames always start from zero state.
   task automatic push_frame(input logic [63:0] bits, input int n, input bit with_tail);
      int tot;
      tot = with_tail ? n + int'(K) - 1 : n;
      for (int t = 0; t < tot; t++) begin
         sym_t s;
         logic c1, c0, xv;
         c1 = 1'b0;
         c0 = 1'b0;
         for (int j = 0; j < int'(K); j++) begin
            xv = (t - j >= 0 && t - j < n) ? bits[t-j] : 1'b0;
            c1 ^= G0[int'(K)-1-j] & xv;
            c0 ^= G1[int'(K)-1-j] & xv;
         end
         s.cx   = {c1, c0};
         s.last = with_tail && (t == tot - 1);
         exp_q.push_back(s);
      end
   endtask

   // Monitor: everything sampled on the falling edge, inputs move at posedge+1.
   logic [1:0] prev_cx;
   logic       prev_last;
   bit         prev_stall = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_cx", 32'(cx), 32'(prev_cx));
            check("hold_valid", 32'(cx_valid), 1);
            check("hold_last", 32'(cx_last), 32'(prev_last));
         end
         if (cx_valid && !cx_ready) check("d_ready_stall", 32'(d_ready), 0);
         if (cx_valid) check("busy", 32'(busy), 32'(!cx_last));
         if (cx_valid && cx_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_sym", 32'(cx), 32'hdead);
            end else begin
               sym_t e;
               e = exp_q.pop_front();
               check("cx", 32'(cx), 32'(e.cx));
               check("cx_last", 32'(cx_last), 32'(e.last));
               if (cx_last) check("s_zero", 32'(dut.u_core.sr), 0);
            end
            n_cons++;
         end
         prev_stall = cx_valid && !cx_ready;
         prev_cx    = cx;
         prev_last  = cx_last;
      end
   end

   logic [7:0] stall_done = '0;
   int         hold = 0;
   always @(posedge clk) begin
      int idx;
      #1;
      if (rdy_mode == 2) begin
         idx = n_cons - stall_base + 1;
         if (hold > 0) begin
            hold--;
            cx_ready = 1'b0;
         end else if (cx_valid && (idx == 2 || idx == 5) && !stall_done[idx]) begin
            stall_done[idx] = 1'b1;
            hold = 2;
            cx_ready = 1'b0;
         end else begin
            cx_ready = 1'b1;
         end
      end else begin
         stall_done = '0;
         hold = 0;
         cx_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Drives one frame; first_wait counts cycles the first bit waited on d_ready.
   task automatic send_frame(input logic [63:0] bits, input int n, input bit with_tail,
                             input bit keep_valid, input bit gaps, output int first_wait);
      int waits;
      first_wait = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            d_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         d_valid = 1'b1;
         d_in    = bits[i];
         d_last  = with_tail && (i == n - 1);
         waits   = 0;
         forever begin
            @(negedge clk);
            if (d_ready) break;
            waits++;
            if (waits > 300) begin
               check("d_ready_timeout", 0, 1);
               break;
            end
         end
         if (i == 0) first_wait = waits;
         @(posedge clk);
         #1;
      end
      d_last = 1'b0;
      if (!keep_valid) d_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      if (t >= 500) check("drain_timeout", 32'(exp_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] f1;
      logic [63:0] fb;
      int          w;
      int          remaining;
      f1 = 64'b1101;   // bits 1,0,1,1 sent LSB first

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cx", 32'(cx), 0);
      check("rst_cx_valid", 32'(cx_valid), 0);
      check("rst_cx_last", 32'(cx_last), 0);
      check("rst_d_ready", 32'(d_ready), 0);
      check("rst_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Scenario 1: plain frame, always ready; expect 3,2,0,1,1,3
      rdy_mode = 0;
      push_frame(f1, 4, 1'b1);
      check("model_s1_first", 32'(exp_q[0].cx), 3);
      check("model_s1_last", 32'(exp_q[5].cx), 3);
      send_frame(f1, 4, 1'b1, 1'b0, 1'b0, w);
      drain();

      // Scenario 2: scripted stalls on symbols 2 and 5
      stall_base = n_cons;
      rdy_mode = 2;
      @(posedge clk);
      #1;
      push_frame(f1, 4, 1'b1);
      send_frame(f1, 4, 1'b1, 1'b0, 1'b0, w);
      drain();
      rdy_mode = 0;
      @(posedge clk);
      #1;

      // Scenario 3 + 5: 1-bit frame, back-to-back frame with d_valid held through TAIL
      fb = 64'b1;
      push_frame(fb, 1, 1'b1);
      send_frame(fb, 1, 1'b1, 1'b1, 1'b0, w);
      fb = 64'b011;
      push_frame(fb, 3, 1'b1);
      send_frame(fb, 3, 1'b1, 1'b0, 1'b0, w);
      check("tail_block_cycles", 32'(w), K - 1);
      drain();

      // Scenario 4: reset mid-frame after two symbols
      push_frame(f1, 2, 1'b0);
      send_frame(f1, 2, 1'b0, 1'b0, 1'b0, w);
      drain();
      check("busy_midframe", 32'(busy), 1);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_cx", 32'(cx), 0);
      check("midrst_cx_valid", 32'(cx_valid), 0);
      check("midrst_cx_last", 32'(cx_last), 0);
      check("midrst_d_ready", 32'(d_ready), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_s", 32'(dut.u_core.sr), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      push_frame(f1, 4, 1'b1);
      send_frame(f1, 4, 1'b1, 1'b0, 1'b0, w);
      drain();

      // Scenario 6: 40 random bits in random frames, random backpressure and gaps
      rdy_mode = 1;
      remaining = 40;
      while (remaining > 0) begin
         int n;
         n  = int'($urandom_range(1, (remaining < 12) ? remaining : 12));
         fb = {$urandom, $urandom};
         push_frame(fb, n, 1'b1);
         send_frame(fb, n, 1'b1, 1'($urandom_range(0, 1)), 1'b1, w);
         remaining -= n;
      end
      drain();
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 0);
      check("idle_at_end", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
